// File: rtl/column_render_sequencer_pkg.sv
// Shared constants and state encoding for the column render sequencer.
// Defaults target a 160x120 raycast view with 3-bit colour.
package column_render_sequencer_pkg;

  localparam int DEF_SCREEN_W     = 160;
  localparam int DEF_SCREEN_H     = 120;
  localparam int DEF_CALC_TIMEOUT = 1023;

  localparam int COL_W = 8;
  localparam int ROW_W = 7;
  localparam int CLR_W = 3;

  localparam logic [CLR_W-1:0] DEF_CEIL_COL  = 3'b001;
  localparam logic [CLR_W-1:0] DEF_WALL_COL  = 3'b110;
  localparam logic [CLR_W-1:0] DEF_FLOOR_COL = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_CALC,
    S_LATCH,
    S_DRAW,
    S_NEXT,
    S_DONE
  } state_t;

endpackage

// File: rtl/column_render_sequencer_if.sv
// Slice-calculator request port plus VGA plot port.
// master = sequencer, slave = calculator/adapter side.
interface column_render_sequencer_if;
  import column_render_sequencer_pkg::*;

  logic [COL_W-1:0] column_count;
  logic             begin_calc;
  logic             end_calc;
  logic [ROW_W-1:0] slice_size;
  logic [COL_W-1:0] x;
  logic [ROW_W-1:0] y;
  logic [CLR_W-1:0] colour;
  logic             plot;

  modport master (
    output column_count, begin_calc,
    output x, y, colour, plot,
    input  end_calc, slice_size
  );

  modport slave (
    input  column_count, begin_calc,
    input  x, y, colour, plot,
    output end_calc, slice_size
  );

endinterface

// File: rtl/column_render_sequencer_slice_span.sv
// Clamps a slice height to the screen and centres it vertically.
// Pure combinational; shared with the later shaded renderers.
module slice_span_calc
  import column_render_sequencer_pkg::*;
#(
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic [ROW_W-1:0] slice_size,
  output logic [ROW_W-1:0] size,
  output logic [7:0]       top,
  output logic [7:0]       bot
);

  localparam logic [7:0] H8 = 8'(SCREEN_H);

  logic [7:0] size8;

  // clamp the requested height to the column height
  always_comb begin
    size8 = {1'b0, slice_size};
    if (size8 > H8) size8 = H8;
  end

  assign size = size8[ROW_W-1:0];
  assign top  = (H8 - size8) >> 1;
  assign bot  = top + size8;

endmodule

// File: rtl/column_render_sequencer.sv
// Frame sweep: request a slice per column, then plot it top to bottom.
// All pins are registered; plot lags the DRAW state by one cycle.
module column_render_sequencer
  import column_render_sequencer_pkg::*;
#(
  parameter int SCREEN_W              = DEF_SCREEN_W,
  parameter int SCREEN_H              = DEF_SCREEN_H,
  parameter int CALC_TIMEOUT          = DEF_CALC_TIMEOUT,
  parameter logic [CLR_W-1:0] CEIL_C  = DEF_CEIL_COL,
  parameter logic [CLR_W-1:0] WALL_C  = DEF_WALL_COL,
  parameter logic [CLR_W-1:0] FLOOR_C = DEF_FLOOR_COL
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       start_frame,
  column_render_sequencer_if.master  bus,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       calc_timeout
);

  localparam int WDW = $clog2(CALC_TIMEOUT + 1);
  localparam logic [WDW-1:0]   WD_MAX   = WDW'(CALC_TIMEOUT);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(SCREEN_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SCREEN_H - 1);

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [WDW-1:0]   wdog;
  logic [7:0]       top_q;
  logic [7:0]       bot_q;

  logic [ROW_W-1:0] span_in;
  logic [ROW_W-1:0] unused_span_size;
  logic [7:0]       span_top;
  logic [7:0]       span_bot;
  logic [7:0]       row_ext;
  logic [CLR_W-1:0] pix_colour;

  // outside LATCH the span sees 0, which is the timeout column shape
  assign span_in = (state == S_LATCH) ? bus.slice_size : '0;
  assign row_ext = {1'b0, row};
  assign bus.column_count = col;

  slice_span_calc #(
    .SCREEN_H (SCREEN_H)
  ) u_span (
    .slice_size (span_in),
    .size       (unused_span_size),
    .top        (span_top),
    .bot        (span_bot)
  );

  // pick the band colour for the row being drawn
  always_comb begin
    pix_colour = FLOOR_C;
    unique case (1'b1)
      (row_ext < top_q):                     pix_colour = CEIL_C;
      (row_ext >= top_q && row_ext < bot_q): pix_colour = WALL_C;
      (row_ext >= bot_q):                    pix_colour = FLOOR_C;
    endcase
  end

  // sequencer FSM with counters, watchdog and registered pins
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state          <= S_IDLE;
      col            <= '0;
      row            <= '0;
      wdog           <= '0;
      top_q          <= '0;
      bot_q          <= '0;
      bus.begin_calc <= 1'b0;
      bus.plot       <= 1'b0;
      bus.x          <= '0;
      bus.y          <= '0;
      bus.colour     <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      calc_timeout   <= 1'b0;
    end else begin
      bus.begin_calc <= 1'b0;
      bus.plot       <= 1'b0;
      frame_done     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_frame) begin
            col            <= '0;
            wdog           <= '0;
            calc_timeout   <= 1'b0;
            busy           <= 1'b1;
            bus.begin_calc <= 1'b1;
            state          <= S_REQ;
          end
        end
        S_REQ, S_WAIT_CALC: begin
          if (wdog == WD_MAX) begin
            calc_timeout <= 1'b1;
            top_q        <= span_top;
            bot_q        <= span_bot;
            row          <= '0;
            state        <= S_DRAW;
          end else begin
            wdog <= wdog + 1'b1;
            if (state == S_REQ) begin
              if (!bus.end_calc) state <= S_WAIT_CALC;
              else bus.begin_calc <= 1'b1;
            end else if (bus.end_calc) begin
              state <= S_LATCH;
            end
          end
        end
        S_LATCH: begin
          top_q <= span_top;
          bot_q <= span_bot;
          row   <= '0;
          state <= S_DRAW;
        end
        S_DRAW: begin
          bus.plot   <= 1'b1;
          bus.x      <= col;
          bus.y      <= row;
          bus.colour <= pix_colour;
          if (row == LAST_ROW) state <= S_NEXT;
          else row <= row + 7'd1;
        end
        S_NEXT: begin
          if (col == LAST_COL) begin
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            col            <= col + 8'd1;
            wdog           <= '0;
            bus.begin_calc <= 1'b1;
            state          <= S_REQ;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_column_render_sequencer.sv
// Frame-level bench: table of frames, calculator model, pixel scoreboard.
// Geometry 4x8, calculator timeout 15 cycles.
module tb_column_render_sequencer;
  import column_render_sequencer_pkg::*;

  localparam int W  = 4;
  localparam int H  = 8;
  localparam int TO = 15;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic start_frame = 1'b0;
  logic busy;
  logic frame_done;
  logic calc_timeout;

  column_render_sequencer_if bus();

  column_render_sequencer #(
    .SCREEN_W     (W),
    .SCREEN_H     (H),
    .CALC_TIMEOUT (TO)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .start_frame  (start_frame),
    .bus          (bus),
    .busy         (busy),
    .frame_done   (frame_done),
    .calc_timeout (calc_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    int sizes[4];
    int lat;
    int stale;
    int drop;
    int top[4];
    int wall[4];
    int bc;
    int tmo;
  } vec_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  vec_t tbl[5];
  pix_t sb[$];

  int total = 0;
  int bad = 0;
  int plots = 0;
  int fdones = 0;
  int bcs = 0;

  int m_sizes[4];
  int m_lat = 1;
  int m_stale = 0;
  int m_drop = -1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // calculator model: answers after m_lat cycles, optional stale hold
  initial begin
    bit prev_bc;
    bit active;
    int hold;
    int cnt;
    int rcol;
    prev_bc = 0;
    active = 0;
    hold = 0;
    cnt = 0;
    rcol = 0;
    bus.end_calc = 1'b0;
    bus.slice_size = '0;
    forever begin
      @(posedge clock);
      #1;
      if (!resetn) begin
        bus.end_calc = 1'b0;
        prev_bc = 0;
        active = 0;
      end else begin
        if (bus.begin_calc && !prev_bc) begin
          active = 1;
          hold = m_stale;
          cnt = m_lat;
          rcol = int'(bus.column_count);
        end
        prev_bc = bus.begin_calc;
        if (active) begin
          if (hold > 0) hold--;
          else bus.end_calc = 1'b0;
          if (cnt > 0) cnt--;
          else if (rcol != m_drop) begin
            bus.end_calc = 1'b1;
            bus.slice_size = 7'(m_sizes[rcol]);
            active = 0;
          end
        end
      end
    end
  end

  // output monitor and scoreboard
  logic bc_prev = 1'b0;
  logic e_prev = 1'b0;
  always @(negedge clock) begin
    pix_t e;
    if (bus.plot) begin
      plots++;
      chk("plot_vs_begin_calc", int'(bus.begin_calc), 0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_plot: got x=%0d y=%0d expected none",
                 bus.x, bus.y);
      end else begin
        e = sb.pop_front();
        total++;
        if (bus.x !== e.x || bus.y !== e.y || bus.colour !== e.c) begin
          bad++;
          $display("FAIL pixel: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                   bus.x, bus.y, bus.colour, e.x, e.y, e.c);
        end
      end
    end
    if (frame_done) fdones++;
    if (bus.begin_calc) bcs++;
    if (bc_prev && !bus.begin_calc && resetn)
      chk("req_exit_end_calc_low", int'(e_prev), 0);
    bc_prev = bus.begin_calc;
    e_prev = bus.end_calc;
  end

  task automatic push_frame(input vec_t v);
    pix_t p;
    for (int c = 0; c < W; c++) begin
      for (int r = 0; r < H; r++) begin
        p.x = 8'(c);
        p.y = 7'(r);
        if (r < v.top[c]) p.c = DEF_CEIL_COL;
        else if (r < v.top[c] + v.wall[c]) p.c = DEF_WALL_COL;
        else p.c = DEF_FLOOR_COL;
        sb.push_back(p);
      end
    end
  endtask

  task automatic setup_frame(input vec_t v);
    m_sizes = v.sizes;
    m_lat = v.lat;
    m_stale = v.stale;
    m_drop = v.drop;
    plots = 0;
    fdones = 0;
    bcs = 0;
    push_frame(v);
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1 start_frame = 1'b1;
    @(posedge clock);
    #1 start_frame = 1'b0;
  endtask

  task automatic run_frame(input int i);
    vec_t v;
    int n;
    v = tbl[i];
    setup_frame(v);
    pulse_start();
    chk("busy_after_start", int'(busy), 1);
    chk("timeout_cleared_on_start", int'(calc_timeout), 0);
    repeat (10) @(posedge clock);
    #1 start_frame = 1'b1;
    @(posedge clock);
    #1 start_frame = 1'b0;
    n = 0;
    while (!frame_done && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) chk("frame_done_wait", 0, 1);
    repeat (3) @(negedge clock);
    chk("plot_count", plots, W * H);
    chk("frame_done_pulses", fdones, 1);
    chk("begin_calc_cycles", bcs, v.bc);
    chk("scoreboard_left", sb.size(), 0);
    chk("busy_after_frame", int'(busy), 0);
    chk("calc_timeout_end", int'(calc_timeout), v.tmo);
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = '{'{4, 2, 8, 0}, 5, 0, -1,
               '{2, 3, 0, 4}, '{4, 2, 8, 0}, 4, 0};
    tbl[1] = '{'{127, 3, 9, 1}, 3, 0, -1,
               '{0, 2, 0, 3}, '{8, 3, 8, 1}, 4, 0};
    tbl[2] = '{'{5, 6, 7, 2}, 4, 2, -1,
               '{1, 1, 0, 3}, '{5, 6, 7, 2}, 12, 0};
    tbl[3] = '{'{6, 5, 4, 3}, 2, 0, 1,
               '{1, 4, 2, 2}, '{6, 0, 4, 3}, 4, 1};
    tbl[4] = '{'{0, 8, 4, 2}, 1, 0, -1,
               '{4, 0, 2, 3}, '{0, 8, 4, 2}, 4, 0};

    resetn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_begin_calc", int'(bus.begin_calc), 0);
    chk("rst_plot", int'(bus.plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_calc_timeout", int'(calc_timeout), 0);
    chk("rst_x", int'(bus.x), 0);
    chk("rst_y", int'(bus.y), 0);
    chk("rst_colour", int'(bus.colour), 0);
    chk("rst_column_count", int'(bus.column_count), 0);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    chk("idle_busy", int'(busy), 0);
    chk("idle_plots", plots, 0);

    for (int i = 0; i < 5; i++) run_frame(i);

    setup_frame(tbl[0]);
    pulse_start();
    n = 0;
    while (!(bus.plot && bus.x == 8'd2 && bus.y == 7'd3) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) chk("mid_draw_wait", 0, 1);
    resetn = 1'b0;
    @(negedge clock);
    chk("mid_rst_plot", int'(bus.plot), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_begin_calc", int'(bus.begin_calc), 0);
    resetn = 1'b1;
    sb.delete();
    run_frame(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
